// File: rtl/hole_conflict_scanner.sv
// Checks one latched ball position against N_HOLES holes, one hole per clock, with a single shared distance comparator.
// Optional build macro EARLY_EXIT_EN: the scan stops on the first hit instead of visiting every hole.
module hole_conflict_scanner #(
    parameter int COORD_W = 10,
    parameter int N_HOLES = 8,
    parameter int RADIUS  = 16,
    parameter int IDX_W   = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [COORD_W-1:0]           i_bl_x,
    input  logic [COORD_W-1:0]           i_bl_y,
    input  logic [N_HOLES*COORD_W-1:0]   i_hole_x,
    input  logic [N_HOLES*COORD_W-1:0]   i_hole_y,
    input  logic [N_HOLES-1:0]           i_hole_valid,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_conflict,
    output logic [IDX_W-1:0]             o_hit_idx,
    output logic [N_HOLES-1:0]           o_hit_mask
);

    // state | meaning
    // IDLE  | waiting for i_start, results held
    // SCAN  | comparing hole idx_q against the latched ball
    // DONE  | o_done pulse cycle, i_start still ignored
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int SQ_W = 2 * COORD_W;
    localparam logic [SQ_W:0]      RAD_SQ = (SQ_W+1)'(RADIUS * RADIUS);
    localparam logic [IDX_W-1:0]   LAST   = IDX_W'(N_HOLES - 1);

    state_t             state;
    logic [COORD_W-1:0] bl_x_q;
    logic [COORD_W-1:0] bl_y_q;
    logic [IDX_W-1:0]   idx_q;

    logic [COORD_W-1:0] hole_x_arr [N_HOLES];
    logic [COORD_W-1:0] hole_y_arr [N_HOLES];

    for (genvar k = 0; k < N_HOLES; k++) begin : g_unpack
        assign hole_x_arr[k] = i_hole_x[k*COORD_W +: COORD_W];
        assign hole_y_arr[k] = i_hole_y[k*COORD_W +: COORD_W];
    end

    logic [COORD_W-1:0] hx;
    logic [COORD_W-1:0] hy;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [SQ_W-1:0]    sq_x;
    logic [SQ_W-1:0]    sq_y;
    logic [SQ_W:0]      dist_sq;
    logic               hit_now;
    logic               finish;

    // Subtract the smaller from the larger so the edges of the field never wrap.
    always_comb begin
        hx      = hole_x_arr[idx_q];
        hy      = hole_y_arr[idx_q];
        dx      = (bl_x_q >= hx) ? (bl_x_q - hx) : (hx - bl_x_q);
        dy      = (bl_y_q >= hy) ? (bl_y_q - hy) : (hy - bl_y_q);
        sq_x    = SQ_W'(dx) * SQ_W'(dx);
        sq_y    = SQ_W'(dy) * SQ_W'(dy);
        dist_sq = (SQ_W+1)'(sq_x) + (SQ_W+1)'(sq_y);
        hit_now = i_hole_valid[idx_q] && (dist_sq <= RAD_SQ);
    end

`ifdef EARLY_EXIT_EN
    assign finish = (idx_q == LAST) || hit_now;
`else
    assign finish = (idx_q == LAST);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            bl_x_q     <= '0;
            bl_y_q     <= '0;
            idx_q      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_conflict <= 1'b0;
            o_hit_idx  <= '0;
            o_hit_mask <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        bl_x_q     <= i_bl_x;
                        bl_y_q     <= i_bl_y;
                        idx_q      <= '0;
                        o_conflict <= 1'b0;
                        o_hit_idx  <= '0;
                        o_hit_mask <= '0;
                        o_busy     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_now) begin
                        o_hit_mask[idx_q] <= 1'b1;
                        o_conflict        <= 1'b1;
                        if (!o_conflict) begin
                            o_hit_idx <= idx_q;
                        end
                    end
                    if (finish) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hole_conflict_scanner.sv
// Self-checking bench for hole_conflict_scanner: directed scenarios plus randomized scans against a distance model.
module tb_hole_conflict_scanner;

    localparam int CW = 10;
    localparam int NH = 8;
    localparam int R  = 16;
    localparam int IW = 3;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic [CW-1:0]     i_bl_x = '0;
    logic [CW-1:0]     i_bl_y = '0;
    logic [NH*CW-1:0]  i_hole_x = '0;
    logic [NH*CW-1:0]  i_hole_y = '0;
    logic [NH-1:0]     i_hole_valid = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_conflict;
    logic [IW-1:0]     o_hit_idx;
    logic [NH-1:0]     o_hit_mask;

    hole_conflict_scanner #(.COORD_W(CW), .N_HOLES(NH), .RADIUS(R), .IDX_W(IW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_bl_x(i_bl_x), .i_bl_y(i_bl_y),
        .i_hole_x(i_hole_x), .i_hole_y(i_hole_y), .i_hole_valid(i_hole_valid),
        .o_busy(o_busy), .o_done(o_done), .o_conflict(o_conflict),
        .o_hit_idx(o_hit_idx), .o_hit_mask(o_hit_mask)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    int hx [NH];
    int hy [NH];
    bit hv [NH];

    logic [NH-1:0] exp_mask;
    logic [IW-1:0] exp_idx;
    logic          exp_conf;
    int            exp_lat;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_holes();
        for (int k = 0; k < NH; k++) begin
            i_hole_x[k*CW +: CW] = hx[k][CW-1:0];
            i_hole_y[k*CW +: CW] = hy[k][CW-1:0];
            i_hole_valid[k]      = hv[k];
        end
    endtask

    task automatic far_holes();
        for (int k = 0; k < NH; k++) begin
            hx[k] = 600; hy[k] = 600; hv[k] = 1'b1;
        end
    endtask

    // Reference: plain integer Euclidean test over the hole list.
    task automatic model(input int bx, input int by);
        bit first_found;
        int dx, dy;
        exp_mask = '0; exp_idx = '0; exp_conf = 1'b0; exp_lat = NH;
        first_found = 0;
        for (int k = 0; k < NH; k++) begin
            dx = bx - hx[k]; if (dx < 0) dx = -dx;
            dy = by - hy[k]; if (dy < 0) dy = -dy;
            if (!first_found && hv[k] && (dx*dx + dy*dy <= R*R)) begin
                first_found = 1;
                exp_idx  = IW'(k);
                exp_conf = 1'b1;
                exp_mask[k] = 1'b1;
`ifdef EARLY_EXIT_EN
                exp_lat = k + 1;
`endif
            end else if (first_found && hv[k] && (dx*dx + dy*dy <= R*R)) begin
`ifndef EARLY_EXIT_EN
                exp_mask[k] = 1'b1;
`endif
            end
`ifdef EARLY_EXIT_EN
            if (first_found) break;
`endif
        end
    endtask

    task automatic run_scan(input int bx, input int by, input string name);
        int cyc;
        load_holes();
        model(bx, by);
        i_bl_x = CW'(bx); i_bl_y = CW'(by);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_bl_x = CW'($urandom); i_bl_y = CW'($urandom);
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_start busy=%b done=%b required busy=1 done=0", name, o_busy, o_done);
        end
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== exp_lat) begin
            failures++;
            $display("FAIL %s latency got=%0d required=%0d", name, cyc, exp_lat);
        end
        checks++;
        if (o_conflict !== exp_conf || o_hit_idx !== exp_idx || o_hit_mask !== exp_mask || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s results got conf=%b idx=%0d mask=%h busy=%b required conf=%b idx=%0d mask=%h busy=0",
                     name, o_conflict, o_hit_idx, o_hit_mask, o_busy, exp_conf, exp_idx, exp_mask);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_hit_mask !== exp_mask) begin
            failures++;
            $display("FAIL %s done_pulse got done=%b busy=%b mask=%h required done=0 busy=0 mask=%h",
                     name, o_done, o_busy, o_hit_mask, exp_mask);
        end
    endtask

    task automatic test_reset();
        int dones;
        i_rst = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_conflict !== 1'b0 || o_hit_idx !== '0 || o_hit_mask !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b conf=%b idx=%0d mask=%h required all 0",
                     o_busy, o_done, o_conflict, o_hit_idx, o_hit_mask);
        end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_done === 1'b1 || o_busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL idle_no_done got activity=%0d required 0", dones);
        end
    endtask

    task automatic test_boundary();
        far_holes();
        hx[3] = 116; hy[3] = 100;
        run_scan(100, 100, "boundary_hit");
        checks++;
        if (o_hit_mask !== 8'h08 || o_hit_idx !== 3'd3 || o_conflict !== 1'b1) begin
            failures++;
            $display("FAIL boundary_hit_literal mask=%h idx=%0d conf=%b required 08 3 1", o_hit_mask, o_hit_idx, o_conflict);
        end
        hx[3] = 117;
        run_scan(100, 100, "boundary_miss");
        checks++;
        if (o_hit_mask !== 8'h00 || o_conflict !== 1'b0 || o_hit_idx !== 3'd0) begin
            failures++;
            $display("FAIL boundary_miss_literal mask=%h idx=%0d conf=%b required 00 0 0", o_hit_mask, o_hit_idx, o_conflict);
        end
    endtask

    task automatic test_multi_invalid();
        far_holes();
        hx[2] = 100; hy[2] = 110; hv[2] = 1'b0;
        hx[5] = 100; hy[5] = 110;
        run_scan(100, 100, "multi_invalid");
        checks++;
        if (o_hit_mask !== 8'h20 || o_hit_idx !== 3'd5) begin
            failures++;
            $display("FAIL multi_invalid_literal mask=%h idx=%0d required 20 5", o_hit_mask, o_hit_idx);
        end
        hv[2] = 1'b1;
        run_scan(100, 100, "multi_valid");
        checks++;
`ifdef EARLY_EXIT_EN
        if (o_hit_mask !== 8'h04 || o_hit_idx !== 3'd2) begin
            failures++;
            $display("FAIL multi_valid_literal mask=%h idx=%0d required 04 2", o_hit_mask, o_hit_idx);
        end
`else
        if (o_hit_mask !== 8'h24 || o_hit_idx !== 3'd2) begin
            failures++;
            $display("FAIL multi_valid_literal mask=%h idx=%0d required 24 2", o_hit_mask, o_hit_idx);
        end
`endif
        for (int k = 0; k < NH; k++) hv[k] = 1'b0;
        hx[0] = 100; hy[0] = 100;
        run_scan(100, 100, "all_invalid");
        checks++;
        if (o_hit_mask !== 8'h00 || o_conflict !== 1'b0) begin
            failures++;
            $display("FAIL all_invalid_literal mask=%h conf=%b required 00 0", o_hit_mask, o_conflict);
        end
    endtask

    task automatic test_no_wrap();
        far_holes();
        hx[0] = 1023; hy[0] = 0;
        hx[1] = 1010; hy[1] = 1023;
        run_scan(0, 0, "no_wrap_low");
        checks++;
        if (o_hit_mask !== 8'h00) begin
            failures++;
            $display("FAIL no_wrap_low_literal mask=%h required 00", o_hit_mask);
        end
        run_scan(1023, 1023, "no_wrap_high");
        checks++;
        if (o_hit_mask !== 8'h02 || o_hit_idx !== 3'd1) begin
            failures++;
            $display("FAIL no_wrap_high_literal mask=%h idx=%0d required 02 1", o_hit_mask, o_hit_idx);
        end
    endtask

    task automatic test_start_while_busy();
        int dones;
        far_holes();
        hx[6] = 205; hy[6] = 195;
        load_holes();
        model(200, 200);
        i_bl_x = 10'd200; i_bl_y = 10'd200;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            i_start = (c == 2);
            i_bl_x = 10'd600; i_bl_y = 10'd600;
            tick();
            if (o_done === 1'b1) begin
                dones++;
                checks++;
                if (o_hit_mask !== exp_mask || o_hit_idx !== exp_idx) begin
                    failures++;
                    $display("FAIL busy_start_results mask=%h idx=%0d required %h %0d", o_hit_mask, o_hit_idx, exp_mask, exp_idx);
                end
            end
        end
        i_start = 1'b0;
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL busy_start_done_count got=%0d required 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        far_holes();
        hx[4] = 300; hy[4] = 300;
        run_scan(300, 300, "b2b_first");
        hx[4] = 600;
        run_scan(300, 300, "b2b_second");
        checks++;
        if (o_conflict !== 1'b0 || o_hit_mask !== 8'h00 || o_hit_idx !== 3'd0) begin
            failures++;
            $display("FAIL b2b_cleared conf=%b mask=%h idx=%0d required 0 00 0", o_conflict, o_hit_mask, o_hit_idx);
        end
    endtask

    task automatic test_reset_mid_scan();
        int act;
        far_holes();
        hx[7] = 50; hy[7] = 60;
        load_holes();
        i_bl_x = 10'd50; i_bl_y = 10'd50;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_conflict !== 1'b0 || o_hit_idx !== '0 || o_hit_mask !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs busy=%b done=%b conf=%b idx=%0d mask=%h required all 0",
                     o_busy, o_done, o_conflict, o_hit_idx, o_hit_mask);
        end
        act = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (o_done === 1'b1) act++;
        end
        checks++;
        if (act !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_done got=%0d required 0", act);
        end
        run_scan(50, 50, "after_mid_reset");
    endtask

    task automatic test_random();
        int bx, by;
        for (int t = 0; t < 40; t++) begin
            bx = int'($urandom_range(0, 1023));
            by = int'($urandom_range(0, 1023));
            for (int k = 0; k < NH; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    hx[k] = bx + int'($urandom_range(0, 40)) - 20;
                    hy[k] = by + int'($urandom_range(0, 40)) - 20;
                    if (hx[k] < 0) hx[k] = 0;
                    if (hx[k] > 1023) hx[k] = 1023;
                    if (hy[k] < 0) hy[k] = 0;
                    if (hy[k] > 1023) hy[k] = 1023;
                end else begin
                    hx[k] = int'($urandom_range(0, 1023));
                    hy[k] = int'($urandom_range(0, 1023));
                end
                hv[k] = ($urandom_range(0, 3) != 0);
            end
            run_scan(bx, by, "random");
        end
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_multi_invalid();
        test_no_wrap();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
